// File: rtl/fir_stream_conv.sv
// Streaming transposed-form FIR with loadable coefficients, valid/ready input,
// wrap/saturate output narrowing and a flush/drain sequencer for the convolution tail.
module fir_stream_conv #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned COEF_W = 4,
    parameter int unsigned N_TAPS = 4,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SAT    = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] X,
    input  logic              X_VALID,
    output logic              X_READY,
    input  logic              COEF_WE,
    input  logic [4:0]        COEF_ADDR,
    input  logic [COEF_W-1:0] COEF_DATA,
    input  logic              FLUSH,
    output logic [OUT_W-1:0]  Y_OUT,
    output logic              Y_VALID,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(N_TAPS);
    localparam int unsigned CNT_W  = 5;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               adv_c;
    logic               done_nxt;
    logic               coef_wr_c;
    logic [DATA_W-1:0]  x_op;
    logic [COEF_W-1:0]  h    [N_TAPS];
    logic [ACC_W-1:0]   prod [N_TAPS];
    logic [ACC_W-1:0]   acc;
    logic [OUT_W-1:0]   y_nar;

    // Sequencer: RUN accepts samples, DRAIN feeds zeros for N_TAPS-1 cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        adv_c     = 1'b0;
        x_op      = '0;
        case (state)
            RUN: begin
                adv_c = X_VALID;
                x_op  = X;
                if (FLUSH) begin
                    if (N_TAPS == 1) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_W'(N_TAPS - 1);
                    end
                end
            end
            DRAIN: begin
                adv_c   = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign coef_wr_c = (state == RUN) && COEF_WE && (32'(COEF_ADDR) < N_TAPS);

    // Coefficient bank; an advance in the same cycle still sees the old value.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int k = 0; k < N_TAPS; k++) h[k] <= '0;
        end else if (coef_wr_c) begin
            for (int k = 0; k < N_TAPS; k++) begin
                if (COEF_ADDR == 5'(k)) h[k] <= COEF_DATA;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            prod[k] = ACC_W'(PROD_W'(h[k]) * PROD_W'(x_op));
        end
    end

    // Partial-sum chain: s[k] collects the taps above k for later samples.
    generate
        if (N_TAPS > 1) begin : g_chain
            logic [ACC_W-1:0] s    [N_TAPS-1];
            logic [ACC_W-1:0] s_in [N_TAPS-1];
            for (genvar k = 0; k < N_TAPS - 1; k++) begin : g_tap
                if (k == N_TAPS - 2) begin : g_last
                    assign s_in[k] = prod[k+1];
                end else begin : g_mid
                    assign s_in[k] = prod[k+1] + s[k+1];
                end
            end
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    for (int k = 0; k < N_TAPS - 1; k++) s[k] <= '0;
                end else if (adv_c) begin
                    for (int k = 0; k < N_TAPS - 1; k++) s[k] <= s_in[k];
                end
            end
            assign acc = prod[0] + s[0];
        end else begin : g_single
            assign acc = prod[0];
        end
    endgenerate

    generate
        if (ACC_W <= OUT_W) begin : g_ext
            assign y_nar = OUT_W'(acc);
        end else if (SAT != 0) begin : g_sat
            assign y_nar = (|acc[ACC_W-1:OUT_W]) ? '1 : acc[OUT_W-1:0];
        end else begin : g_wrap
            assign y_nar = acc[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= RUN;
            cnt     <= '0;
            Y_OUT   <= '0;
            Y_VALID <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            Y_VALID <= adv_c;
            if (adv_c) Y_OUT <= y_nar;
            BUSY    <= (state_nxt == DRAIN);
            DONE    <= done_nxt;
        end
    end

    assign X_READY = (state == RUN);

endmodule

// File: tb/tb_fir_stream_conv.sv
// Bench for fir_stream_conv: six configurations share one stimulus stream and are
// checked every cycle against a direct convolution model, plus directed value checks.
module tb_fir_stream_conv;

    localparam int ND = 6;

    function automatic int unsigned nt_of(input int d);
        case (d)
            0: return 2;
            4: return 3;
            5: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned ow_of(input int d);
        case (d)
            1, 2: return 4;
            3: return 10;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned sat_of(input int d);
        return (d == 2) ? 1 : 0;
    endfunction

    logic       clk;
    logic       rst_n;
    logic [3:0] x;
    logic       x_valid;
    logic       coef_we;
    logic [4:0] coef_addr;
    logic [3:0] coef_data;
    logic       flush;

    logic [9:0] yd     [ND];
    logic       yv_d   [ND];
    logic       rdy_d  [ND];
    logic       busy_d [ND];
    logic       done_d [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned NTG  = nt_of(g);
        localparam int unsigned OWG  = ow_of(g);
        localparam int unsigned SATG = sat_of(g);
        logic [OWG-1:0] y;
        logic yv, rdy, busy, done;
        fir_stream_conv #(
            .DATA_W(4), .COEF_W(4), .N_TAPS(NTG), .OUT_W(OWG), .SAT(SATG)
        ) u_dut (
            .CLK(clk), .RST_N(rst_n), .X(x), .X_VALID(x_valid), .X_READY(rdy),
            .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
            .FLUSH(flush), .Y_OUT(y), .Y_VALID(yv), .BUSY(busy), .DONE(done)
        );
        assign yd[g]     = 10'(y);
        assign yv_d[g]   = yv;
        assign rdy_d[g]  = rdy;
        assign busy_d[g] = busy;
        assign done_d[g] = done;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: history of advance operands with the coefficient set seen by each.
    int mh   [ND][4];
    int mxs  [ND][4];
    int mhs  [ND][4][4];
    bit mdrain [ND];
    int mcnt [ND];
    int my   [ND];
    bit myv  [ND];
    bit mbusy [ND];
    bit mdone [ND];

    function automatic int narrow(input int acc, input int d);
        int lim;
        lim = (1 << ow_of(d)) - 1;
        if (sat_of(d) != 0) return (acc > lim) ? lim : acc;
        return acc & lim;
    endfunction

    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            int n;
            bit adv;
            int xv;
            int acc;
            n = int'(nt_of(d));
            if (!rst_n) begin
                for (int j = 0; j < 4; j++) begin
                    mh[d][j] = 0;
                    mxs[d][j] = 0;
                    for (int k = 0; k < 4; k++) mhs[d][j][k] = 0;
                end
                mdrain[d] = 0; mcnt[d] = 0; my[d] = 0;
                myv[d] = 0; mbusy[d] = 0; mdone[d] = 0;
                continue;
            end
            adv = mdrain[d] || x_valid;
            xv  = mdrain[d] ? 0 : int'(x);
            if (adv) begin
                for (int j = 3; j > 0; j--) begin
                    mxs[d][j] = mxs[d][j-1];
                    for (int k = 0; k < 4; k++) mhs[d][j][k] = mhs[d][j-1][k];
                end
                mxs[d][0] = xv;
                for (int k = 0; k < 4; k++) mhs[d][0][k] = mh[d][k];
                acc = 0;
                for (int k = 0; k < n; k++) acc += mhs[d][k][k] * mxs[d][k];
                my[d] = narrow(acc, d);
            end
            myv[d]  = adv;
            mdone[d] = 0;
            if (!mdrain[d] && coef_we && int'(coef_addr) < n) mh[d][coef_addr] = int'(coef_data);
            if (!mdrain[d]) begin
                if (flush) begin
                    if (n == 1) mdone[d] = 1;
                    else begin mdrain[d] = 1; mcnt[d] = n - 1; end
                end
            end else begin
                if (mcnt[d] == 1) begin mdrain[d] = 0; mdone[d] = 1; end
                mcnt[d]--;
            end
            mbusy[d] = mdrain[d];
        end
    endtask

    int cap      [ND][64];
    int ncap     [ND];
    int busy_cnt [ND];
    int rdy_low  [ND];
    int yv_cnt   [ND];
    int done_cnt [ND];
    int done_y   [ND];

    task automatic clear_stats();
        for (int d = 0; d < ND; d++) begin
            ncap[d] = 0; busy_cnt[d] = 0; rdy_low[d] = 0;
            yv_cnt[d] = 0; done_cnt[d] = 0; done_y[d] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d y_out", d), 32'(yd[d]), 32'(my[d]));
            check($sformatf("d%0d y_valid", d), 32'(yv_d[d]), 32'(myv[d]));
            check($sformatf("d%0d x_ready", d), 32'(rdy_d[d]), 32'(!mdrain[d]));
            check($sformatf("d%0d busy", d), 32'(busy_d[d]), 32'(mbusy[d]));
            check($sformatf("d%0d done", d), 32'(done_d[d]), 32'(mdone[d]));
            if (yv_d[d] === 1'b1) begin
                yv_cnt[d]++;
                if (ncap[d] < 64) begin cap[d][ncap[d]] = int'(yd[d]); ncap[d]++; end
            end
            if (busy_d[d] === 1'b1) busy_cnt[d]++;
            if (rdy_d[d] === 1'b0) rdy_low[d]++;
            if (done_d[d] === 1'b1) begin done_cnt[d]++; done_y[d] = int'(yd[d]); end
        end
    endtask

    task automatic load4(input int h0, input int h1, input int h2, input int h3);
        int hv[4];
        hv = '{h0, h1, h2, h3};
        for (int k = 0; k < 4; k++) begin
            coef_we = 1'b1; coef_addr = 5'(k); coef_data = 4'(hv[k]);
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic flush_drain();
        x_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
    endtask

    int ref_x [5] = '{1, 2, 2, 1, 1};
    int ref_y [6] = '{1, 4, 6, 5, 3, 2};
    int nar_w [4] = '{1, 2, 3, 4};
    int nar_x [4] = '{225, 450, 675, 900};

    initial begin
        rst_n = 1'b0; x = '0; x_valid = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; flush = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reference convolution with back-to-back samples
        load4(1, 2, 0, 0);
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            x = 4'(ref_x[i]); x_valid = 1'b1;
            tick();
        end
        flush_drain();
        check("ref count", 32'(ncap[0]), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("ref y%0d", i), 32'(cap[0][i]), 32'(ref_y[i]));
        check("ref busy cycles", 32'(busy_cnt[0]), 32'd1);
        check("ref done count", 32'(done_cnt[0]), 32'd1);
        check("ref done value", 32'(done_y[0]), 32'd2);

        // Same stream with random gaps
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            x = 4'(ref_x[i]); x_valid = 1'b1;
            tick();
            x_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        flush_drain();
        check("stall count", 32'(ncap[0]), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("stall y%0d", i), 32'(cap[0][i]), 32'(ref_y[i]));

        // Narrowing at steady state 900
        load4(15, 15, 15, 15);
        clear_stats();
        repeat (4) begin
            x = 4'd15; x_valid = 1'b1;
            tick();
        end
        flush_drain();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap y%0d", i), 32'(cap[1][i]), 32'(nar_w[i]));
            check($sformatf("sat y%0d", i), 32'(cap[2][i]), 32'd15);
            check($sformatf("wide y%0d", i), 32'(cap[3][i]), 32'(nar_x[i]));
        end

        // Coefficient write coincident with an advance, then an out-of-range write
        load4(1, 1, 1, 0);
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            x = 4'd2; x_valid = 1'b1;
            coef_we = (i == 2) || (i == 3);
            coef_addr = (i == 2) ? 5'd0 : 5'd5;
            coef_data = (i == 2) ? 4'd3 : 4'd9;
            tick();
        end
        coef_we = 1'b0;
        flush_drain();
        check("coef y2", 32'(cap[4][2]), 32'd6);
        check("coef y3", 32'(cap[4][3]), 32'd10);
        check("coef y4", 32'(cap[4][4]), 32'd10);

        // Sample with FLUSH, FLUSH repeated inside DRAIN
        clear_stats();
        x = 4'd7; x_valid = 1'b1; flush = 1'b1;
        tick();
        check("n1 done with sample", 32'(done_d[5]), 32'd1);
        check("n1 valid with sample", 32'(yv_d[5]), 32'd1);
        x = 4'd5; x_valid = 1'b1; flush = 1'b1;
        tick();
        x_valid = 1'b0; flush = 1'b0;
        repeat (5) tick();
        check("n4 ready low cycles", 32'(rdy_low[3]), 32'd3);
        check("n4 drain outputs", 32'(yv_cnt[3]), 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("n1 bare flush done", 32'(done_d[5]), 32'd1);
        check("n1 bare flush valid", 32'(yv_d[5]), 32'd0);
        repeat (4) tick();

        // Random traffic
        repeat (400) begin
            x = 4'($urandom_range(0, 15));
            x_valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            coef_we = ($urandom_range(0, 9) == 0);
            coef_addr = 5'($urandom_range(0, 7));
            coef_data = 4'($urandom_range(0, 15));
            tick();
        end
        x_valid = 1'b0; flush = 1'b0; coef_we = 1'b0;
        repeat (5) tick();

        // Reset in the second drain cycle
        load4(1, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            x = 4'(ref_x[i]); x_valid = 1'b1;
            tick();
        end
        x_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst busy", 32'(busy_d[3]), 32'd0);
        check("rst valid", 32'(yv_d[3]), 32'd0);
        clear_stats();
        repeat (4) tick();
        check("rst no done", 32'(done_cnt[3]), 32'd0);
        x = 4'd1; x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("rst fresh valid", 32'(yv_d[0]), 32'd1);
        check("rst fresh y", 32'(yd[0]), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_stream_conv.md
Name: fir_stream_conv

Overview:
- Parametrised streaming transposed-form FIR convolution engine; successor to the fixed two-tap, fixed-coefficient convolution chain.
- Adds:
  - runtime-loadable coefficients
  - configurable tap count and widths
  - valid/ready sample handshake
  - full-precision accumulation with wrap or saturate output
  - a FLUSH/drain state machine that emits the N_TAPS-1 tail samples, giving the full L+N_TAPS-1 convolution length.
- Sits between a sample source (array/stream block) and downstream DSP stages.

Parameters:
- DATA_W, 4: input sample width, unsigned.
- COEF_W, 4: coefficient width, unsigned.
- N_TAPS, 4: number of taps; minimum 1, maximum 32.
- OUT_W, 8: output width.
- SAT, 0: output narrowing mode. 0 keeps the low OUT_W bits (wrap). 1 clamps to 2^OUT_W-1.

Ports:
- CLK, input, 1: clock; all logic on the rising edge.
- RST_N, input, 1: synchronous active-low reset.
- X, input, DATA_W: input sample.
- X_VALID, input, 1: sample present.
- X_READY, output, 1: block can accept a sample.
- COEF_WE, input, 1: coefficient write strobe.
- COEF_ADDR, input, 5: tap index k of h[k].
- COEF_DATA, input, COEF_W: coefficient value.
- FLUSH, input, 1: one-cycle request to drain the tail.
- Y_OUT, output, OUT_W: output sample.
- Y_VALID, output, 1: Y_OUT valid this cycle.
- BUSY, output, 1: high while in DRAIN.
- DONE, output, 1: one-cycle pulse at end of drain.

Behaviour:
- Reset (RST_N low at posedge):
  - h[0..N_TAPS-1] = 0; partial-sum registers s[0..N_TAPS-2] = 0.
  - Y_OUT = 0, Y_VALID = 0, BUSY = 0, DONE = 0.
  - State goes to RUN; drain counter = 0.
  - Reset mid-DRAIN aborts the drain with no DONE.
- Internal width: ACC_W = DATA_W + COEF_W + ceil(log2(N_TAPS)), minimum DATA_W + COEF_W. Partial sums carry full precision and never overflow.
- Advance cycle: one posedge with operand x, where x = X on an accepted sample and x = 0 in DRAIN.
  - acc = h[0]*x + s[0]
  - s[k] <= h[k+1]*x + s[k+1], for k < N_TAPS-2
  - s[N_TAPS-2] <= h[N_TAPS-1]*x
  - Y_OUT <= narrow(acc); Y_VALID <= 1.
  - N_TAPS=1: no s registers; acc = h[0]*x.
- Non-advance cycle: s holds, Y_OUT holds, Y_VALID <= 0.
- Result: y[n] = sum over k of h[k]*x[n-k]. Latency from an accepted sample to Y_VALID is exactly 1 cycle. One output per input, no bubbles added.
- narrow(acc): if ACC_W <= OUT_W, zero-extend. Otherwise, SAT=0 takes acc[OUT_W-1:0]; SAT=1 gives acc > 2^OUT_W-1 ? all ones : acc.
- States:
  - RUN: X_READY = 1; accept when X_VALID. If FLUSH, go to DRAIN with counter = N_TAPS-1. A sample accepted in the same cycle as FLUSH is processed first.
  - DRAIN: X_READY = 0, BUSY = 1; X_VALID ignored. Advance with x=0 each cycle and decrement the counter. At counter = 1, return to RUN.
  - DONE pulses in the cycle that carries Y_VALID of the last drain output. N_TAPS=1: no drain cycles; DONE pulses the cycle after FLUSH with Y_VALID=0.
- After a drain all s registers are 0; a new sequence starts clean and coefficients are retained.
- FLUSH in DRAIN is ignored.
- Coefficient writes:
  - Accepted only in RUN: h[COEF_ADDR] <= COEF_DATA.
  - COEF_ADDR >= N_TAPS is ignored; writes during DRAIN are ignored.
  - A write coincident with an advance: that advance uses the old h; the new value applies from the next advance.
- No X/Z propagation: Y_OUT is always a defined value after reset.

Test Plan:
- Reference convolution: N_TAPS=2, OUT_W=8. Load h=[1,2]; stream x=1,2,2,1,1 back-to-back, then FLUSH.
  - Required Y_VALID outputs: 1,4,6,5,3,2.
  - DONE pulses with the 2; BUSY high for exactly 1 cycle.
- Stalls: same stimulus with X_VALID gaps of 1–3 cycles between samples.
  - Identical output sequence; each Y_VALID exactly 1 cycle after its accepted sample; no Y_VALID in gap cycles.
- Narrowing, N_TAPS=4, h=[15,15,15,15], x=15 repeated 4 times (steady state 900):
  - OUT_W=4, SAT=0: outputs 1,2,3,4 (225,450,675,900 mod 16).
  - OUT_W=4, SAT=1: 15,15,15,15.
  - OUT_W=10: 225,450,675,900.
- Coefficient timing: N_TAPS=3, h=[1,1,1], x=2 stream. Write h[0]=3 on the cycle of the 3rd sample.
  - 3rd output = 6; 4th output = 6+4 = 10.
  - A write to COEF_ADDR=5 leaves all outputs unchanged.
- Drain edges:
  - N_TAPS=4: X_VALID with FLUSH in the same cycle accepts the sample, then 3 drain outputs, with X_READY low for 3 cycles.
  - FLUSH repeated inside DRAIN changes nothing.
  - N_TAPS=1: DONE the cycle after FLUSH.
- Reset: assert RST_N=0 in the 2nd drain cycle of the first scenario.
  - Next cycle: Y_VALID=0, BUSY=0, DONE never pulses, h reads back as 0.
  - A fresh x=1 gives Y_OUT=0.
